axi_c_output_writer: RTL and testbench
======================================

// Module: axi_c_output_writer
// PURPOSE
//  Downstream stage of the 8x8 systolic array. It consumes the diagonally skewed result stream (one byte per row lane per cycle)
//  and de-skews it into an 8x8 byte matrix C.
//  Once all 15 diagonals are captured, it writes C to memory as one 16-beat AXI4 INCR write burst on S_AXI_1.
//  It then pulses done and returns to collecting.
// PARAMETERS
//  BASE_ADDR  12'd64  byte address of C in memory; word-aligned
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous, active-high reset
//  collect_reset  in   1   pulse: clear diagonal mask and c_overrun; abort any burst not yet accepted on AW
//  c_valid        in   1   c_flat_in/c_cycle valid this cycle
//  c_cycle        in   4   diagonal index t, 0..14
//  c_flat_in      in   64  lane i = bits[i*8+:8] = C[i][t-i]
//  busy           out  1   high from AW issue until B accepted
//  done           out  1   one-cycle pulse when B response accepted
//  write_error    out  1   bresp!=0 on last burst; held until next burst completes
//  c_overrun      out  1   sticky: c_valid seen while busy
//  m_axi_awaddr/awlen/awsize/awburst/awvalid  out 12/8/3/2/1
//  m_axi_awready  in   1
//  m_axi_wdata/wstrb/wlast/wvalid             out 32/4/1/1
//  m_axi_wready   in   1
//  m_axi_bresp/bvalid  in  2/1
//  m_axi_bready   out  1
// BEHAVIOUR
//  Reset: every output 0; c_matrix 0; diag_mask 0; state S_COLLECT.
//  Capture (S_COLLECT, c_valid): for each lane i with 0<=t-i<=7, write c_flat_in[i*8+:8] to C[i][t-i].
//   Set diag_mask[t]. Lanes outside that range are ignored. t=15 is ignored entirely.
//   A repeated t overwrites its bytes; the mask is unchanged.
//  Transition: the cycle after diag_mask==15'h7FFF -> S_ADDR.
//   Drive awvalid=1, awaddr=BASE_ADDR, awlen=15, awsize=3'b010, awburst=2'b01. Set busy=1.
//  S_ADDR: hold all AW signals stable until awvalid&&awready. Then awvalid=0, beat=0 -> S_DATA.
//  S_DATA: wvalid=1 and wstrb=4'hF. wdata = word[beat]; word[2i]=C row i bytes 0..3, word[2i+1]=bytes 4..7.
//   Byte j of a row sits at bits j*8 of the 64-bit row. wlast = (beat==15).
//   Hold wdata/wlast stable while wvalid&&!wready. Increment beat on wvalid&&wready.
//   On the handshake with wlast: wvalid=0, bready=1 -> S_RESP. W never starts before AW is accepted.
//  S_RESP: on bvalid&&bready: bready=0, write_error<=(bresp!=2'b00), done=1 for one cycle, busy=0.
//   diag_mask cleared; -> S_COLLECT.
//  c_valid in S_ADDR/S_DATA/S_RESP: data dropped; c_overrun<=1.
//  collect_reset in S_COLLECT or S_ADDR: mask cleared; awvalid=0; -> S_COLLECT.
//   In S_DATA/S_RESP it is deferred: the burst completes (AXI rule), then the mask is cleared.
//  rst overrides all, including mid-burst; the interconnect shares rst.
//  Simultaneous collect_reset and c_valid in S_COLLECT: reset wins; data dropped.
//  Latency: last diagonal -> awvalid = 1 cycle; minimum total to done = 1+1+16+1 cycles with zero-wait slave.
// STRUCTURE
//  Shared package (lstm_acc_pkg): MAT_N=8, AXI_SIZE_4B=3'b010, AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00,
//   and the state enum typedef.
//  Sub-module c_deskew_buffer: lane-wise capture into C plus diag_mask/full flag; combinational word[beat] read port.
//  Top level: AXI write FSM, beat counter, status flags.
// TESTING
//  1. Feed t=0..14 from C[i][j]=8*i+j, zero-wait slave -> awaddr=64, awlen=15; 16 beats.
//     word0=32'h03020100, word15=32'h3F3E3D3C; wlast on beat 15 only; done pulses once.
//  2. Same data, wready low 2 of every 3 cycles and awready delayed 5 cycles -> identical data sequence.
//     AW and W signals stable while stalled.
//  3. bresp=2'b10 -> write_error=1 with done. Next burst with bresp=0 -> write_error=0.
//  4. Diagonals sent out of order (14 down to 0), t=5 sent twice (second copy differs), plus t=15 injected.
//     -> burst starts only after all 15; second t=5 data written; t=15 ignored.
//  5. c_valid during S_DATA -> c_overrun=1 and written data unaffected; collect_reset clears c_overrun.
//  6. collect_reset in S_ADDR before awready -> awvalid drops, no W beats. rst mid-S_DATA -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/lstm_acc_pkg.sv
// lstm_acc_pkg: shared constants and FSM state type for the accelerator datapath
package lstm_acc_pkg;
    localparam int         MAT_N          = 8;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    typedef enum logic [1:0] {S_COLLECT, S_ADDR, S_DATA, S_RESP} wr_state_t;
endpackage

// File: rtl/c_deskew_buffer.sv
// c_deskew_buffer: de-skews diagonal result lanes into the 8x8 byte matrix C
//  i_clear  clear diagonal mask        i_wr   capture i_data as diagonal i_t
//  i_beat   word index for o_word      o_full all 15 diagonals captured
//  o_word   32-bit word: row i_beat/2, bytes 0..3 (even) or 4..7 (odd)
module c_deskew_buffer
    import lstm_acc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_wr,
    input  logic [3:0]  i_t,
    input  logic [63:0] i_data,
    input  logic [3:0]  i_beat,
    output logic        o_full,
    output logic [31:0] o_word
);
    // row i packs byte j at bits j*8, so a 4-byte slice is directly an AXI word
    logic [MAT_N-1:0][7:0] r_c [MAT_N];
    logic [14:0]           r_mask;
    logic                  w_we;
    assign w_we = i_wr && i_t != 4'd15;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c    <= '{default: '0};
            r_mask <= '0;
        end else begin
            // lane i carries C[i][t-i]; lanes whose column falls outside 0..7 are ignored
            for (int i = 0; i < MAT_N; i++)
                if (w_we && i_t >= 4'(i) && i_t - 4'(i) <= 4'd7)
                    r_c[i][3'(i_t - 4'(i))] <= i_data[i*8+:8];
            r_mask <= i_clear ? '0 : (w_we ? r_mask | (15'd1 << i_t) : r_mask);
        end
    end
    assign o_full = &r_mask;
    assign o_word = i_beat[0] ? r_c[i_beat[3:1]][7:4] : r_c[i_beat[3:1]][3:0];
endmodule

// File: rtl/axi_c_output_writer.sv
// axi_c_output_writer: collects the skewed systolic result into C and writes it as one 16-beat AXI4 burst
//  clk/rst                 clock, synchronous active-high reset
//  collect_reset           clear mask and c_overrun; abort a burst whose AW is not yet accepted
//  c_valid/c_cycle/c_flat_in  diagonal result stream
//  busy/done/write_error/c_overrun  status
//  m_axi_aw*/w*/b*         AXI4 write channels (S_AXI_1)
module axi_c_output_writer
    import lstm_acc_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR = 12'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        collect_reset,
    input  logic        c_valid,
    input  logic [3:0]  c_cycle,
    input  logic [63:0] c_flat_in,
    output logic        busy,
    output logic        done,
    output logic        write_error,
    output logic        c_overrun,
    output logic [11:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);
    wr_state_t   r_state;
    logic [3:0]  r_beat;
    logic        w_full;
    logic [31:0] w_word;
    logic        w_b_hs;
    assign w_b_hs = r_state == S_RESP && m_axi_bvalid;
    // clearing the mask mid-burst is harmless: C itself is untouched and the mask is cleared again on B
    c_deskew_buffer u_buf (
        .clk    (clk),
        .rst    (rst),
        .i_clear(collect_reset || w_b_hs),
        .i_wr   (r_state == S_COLLECT && c_valid && !collect_reset),
        .i_t    (c_cycle),
        .i_data (c_flat_in),
        .i_beat (r_beat),
        .o_full (w_full),
        .o_word (w_word)
    );
    assign m_axi_wdata = m_axi_wvalid ? w_word : '0;
    assign m_axi_wstrb = m_axi_wvalid ? 4'hF : 4'h0;
    assign m_axi_wlast = m_axi_wvalid && r_beat == 4'd15;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_COLLECT;
            r_beat        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            write_error   <= 1'b0;
            c_overrun     <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awlen   <= '0;
            m_axi_awsize  <= '0;
            m_axi_awburst <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (collect_reset)
                c_overrun <= 1'b0;
            else if (c_valid && busy)
                c_overrun <= 1'b1;
            case (r_state)
                S_COLLECT:
                    if (w_full && !collect_reset) begin
                        r_state       <= S_ADDR;
                        m_axi_awvalid <= 1'b1;
                        m_axi_awaddr  <= BASE_ADDR;
                        m_axi_awlen   <= 8'd15;
                        m_axi_awsize  <= AXI_SIZE_4B;
                        m_axi_awburst <= AXI_BURST_INCR;
                        busy          <= 1'b1;
                    end
                // an AW handshake in the same cycle as collect_reset commits the burst
                S_ADDR:
                    if (m_axi_awready) begin
                        r_state       <= S_DATA;
                        m_axi_awvalid <= 1'b0;
                        m_axi_wvalid  <= 1'b1;
                        r_beat        <= '0;
                    end else if (collect_reset) begin
                        r_state       <= S_COLLECT;
                        m_axi_awvalid <= 1'b0;
                        busy          <= 1'b0;
                    end
                S_DATA:
                    if (m_axi_wready) begin
                        r_beat <= r_beat + 4'd1;
                        if (r_beat == 4'd15) begin
                            r_state      <= S_RESP;
                            m_axi_wvalid <= 1'b0;
                            m_axi_bready <= 1'b1;
                        end
                    end
                S_RESP:
                    if (m_axi_bvalid) begin
                        r_state      <= S_COLLECT;
                        m_axi_bready <= 1'b0;
                        write_error  <= m_axi_bresp != AXI_RESP_OKAY;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                    end
                default: r_state <= S_COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_c_output_writer.sv
// tb_axi_c_output_writer: randomized/directed bench against a matrix-level model of the C writer
module tb_axi_c_output_writer;
    logic        clk = 0, rst = 1, collect_reset = 0, c_valid = 0;
    logic [3:0]  c_cycle = 0;
    logic [63:0] c_flat_in = 0;
    logic        busy, done, write_error, c_overrun;
    logic [11:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid, m_axi_awready = 0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready = 0;
    logic [1:0]  m_axi_bresp = 0;
    logic        m_axi_bvalid = 0, m_axi_bready;

    axi_c_output_writer dut (
        .clk(clk), .rst(rst), .collect_reset(collect_reset), .c_valid(c_valid),
        .c_cycle(c_cycle), .c_flat_in(c_flat_in), .busy(busy), .done(done),
        .write_error(write_error), .c_overrun(c_overrun),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    always #5 clk = ~clk;

    int          n_tests = 0, n_fail = 0;
    logic [7:0]  src   [8][8];
    logic [7:0]  exp_c [8][8];
    logic        exp_err = 0;
    logic [31:0] got_w0, got_w15;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input int w);
        int r = w / 2, b = (w % 2) * 4;
        return {exp_c[r][b+3], exp_c[r][b+2], exp_c[r][b+1], exp_c[r][b]};
    endfunction

    function automatic logic [127:0] all_outs;
        return {busy, done, write_error, c_overrun, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
                m_axi_awburst, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
                m_axi_wvalid, m_axi_bready};
    endfunction

    task automatic fill_random;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) src[i][j] = 8'($urandom);
    endtask

    // diagonal t of src with random junk on lanes that carry no matrix element
    function automatic logic [63:0] mk(input int t);
        logic [63:0] v = {$urandom, $urandom};
        for (int i = 0; i < 8; i++)
            if (t - i >= 0 && t - i <= 7) v[i*8+:8] = src[i][t-i];
        return v;
    endfunction

    // model capture rule: lane i -> C[i][t-i] when in range; t=15 writes nothing
    task automatic send(input int t, input logic [63:0] v);
        c_valid = 1; c_cycle = 4'(t); c_flat_in = v;
        if (t < 15)
            for (int i = 0; i < 8; i++)
                if (t - i >= 0 && t - i <= 7) exp_c[i][t-i] = v[i*8+:8];
        tick;
        c_valid = 0;
    endtask

    task automatic send_all;
        for (int t = 0; t < 15; t++) send(t, mk(t));
    endtask

    task automatic wait_aw(input string tag);
        int cyc = 0;
        while (!m_axi_awvalid && cyc < 50) begin tick; cyc++; end
        chk({tag, "_aw_seen"}, m_axi_awvalid, 1);
    endtask

    task automatic run_burst(input string tag, input int aw_delay, input bit stall,
                             input logic [1:0] resp, input bit overrun);
        int beat = 0, cyc = 0;
        bit rdy;
        wait_aw(tag);
        chk({tag, "_awaddr"}, m_axi_awaddr, 64);
        chk({tag, "_awlen"}, m_axi_awlen, 15);
        chk({tag, "_awsize_burst"}, {m_axi_awsize, m_axi_awburst}, {3'b010, 2'b01});
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_err_held"}, write_error, exp_err);
        for (int k = 0; k < aw_delay; k++) begin
            m_axi_awready = 0;
            tick;
            chk({tag, "_aw_stable"}, {m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_wvalid},
                {1'b1, 12'd64, 8'd15, 1'b0});
        end
        m_axi_awready = 1;
        tick;
        m_axi_awready = 0;
        chk({tag, "_aw_drop"}, m_axi_awvalid, 0);
        while (beat < 16 && cyc < 200) begin
            rdy = stall ? (cyc % 3 == 2) : 1;
            m_axi_wready = rdy;
            if (overrun && cyc == 0) begin
                c_valid = 1; c_cycle = 4'($urandom_range(0, 14)); c_flat_in = {$urandom, $urandom};
            end else c_valid = 0;
            if (m_axi_wvalid) begin
                chk({tag, "_wdata"}, m_axi_wdata, exp_word(beat));
                chk({tag, "_wlast"}, m_axi_wlast, beat == 15);
                chk({tag, "_wstrb"}, m_axi_wstrb, 4'hF);
                if (beat == 0) got_w0 = m_axi_wdata;
                if (beat == 15) got_w15 = m_axi_wdata;
                if (rdy) beat++;
            end
            tick;
            cyc++;
        end
        c_valid = 0;
        m_axi_wready = 0;
        chk({tag, "_beats"}, beat, 16);
        chk({tag, "_w_end"}, {m_axi_wvalid, m_axi_bready, done}, 3'b010);
        m_axi_bvalid = 1; m_axi_bresp = resp;
        tick;
        m_axi_bvalid = 0; m_axi_bresp = 0;
        exp_err = resp != 2'b00;
        chk({tag, "_done"}, {done, busy, m_axi_bready, write_error}, {3'b100, exp_err});
        tick;
        chk({tag, "_done_once"}, done, 0);
    endtask

    initial begin
        int wv;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) exp_c[i][j] = 0;
        tick; tick; tick;
        chk("reset_outs", all_outs(), 0);
        rst = 0;
        tick;
        chk("idle_outs", all_outs(), 0);

        // 1: ramp matrix, zero-wait slave
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) src[i][j] = 8'(8 * i + j);
        send_all();
        run_burst("t1", 0, 0, 2'b00, 0);
        chk("t1_word0", got_w0, 32'h03020100);
        chk("t1_word15", got_w15, 32'h3F3E3D3C);

        // 2: same data, stalled AW and W
        send_all();
        run_burst("t2", 5, 1, 2'b00, 0);
        chk("t2_word15", got_w15, 32'h3F3E3D3C);

        // 3: error response then clean response
        fill_random(); send_all();
        run_burst("t3a", 1, 0, 2'b10, 0);
        tick; tick;
        chk("t3_err_sticky", write_error, 1);
        fill_random(); send_all();
        run_burst("t3b", 0, 1, 2'b00, 0);

        // 4: reverse order, duplicate t=5, t=15 injection
        fill_random();
        for (int t = 14; t >= 6; t--) send(t, mk(t));
        send(5, {$urandom, $urandom});
        for (int t = 4; t >= 1; t--) send(t, mk(t));
        tick; tick;
        chk("t4_no_early_aw", {m_axi_awvalid, busy}, 2'b00);
        send(15, {$urandom, $urandom});
        send(5, mk(5));
        tick; tick;
        chk("t4_still_waiting", m_axi_awvalid, 0);
        send(0, mk(0));
        run_burst("t4", 2, 0, 2'b00, 0);

        // 5: overrun during data phase
        chk("t5_ovr_before", c_overrun, 0);
        fill_random(); send_all();
        run_burst("t5", 0, 0, 2'b00, 1);
        chk("t5_ovr_set", c_overrun, 1);
        collect_reset = 1; tick; collect_reset = 0;
        chk("t5_ovr_clear", c_overrun, 0);

        // 6a: abort in address phase
        fill_random(); send_all();
        wait_aw("t6a");
        tick;
        collect_reset = 1; tick; collect_reset = 0;
        chk("t6a_abort", {m_axi_awvalid, busy}, 2'b00);
        m_axi_awready = 1; m_axi_wready = 1;
        wv = 0;
        for (int k = 0; k < 10; k++) begin
            if (m_axi_wvalid || m_axi_awvalid) wv++;
            tick;
        end
        m_axi_awready = 0; m_axi_wready = 0;
        chk("t6a_no_w", wv, 0);

        // 6b: reset in the middle of the data phase
        fill_random(); send_all();
        wait_aw("t6b");
        m_axi_awready = 1; tick; m_axi_awready = 0;
        m_axi_wready = 1; tick; tick;
        chk("t6b_in_data", m_axi_wvalid, 1);
        rst = 1; tick; m_axi_wready = 0;
        chk("t6b_rst_outs", all_outs(), 0);
        rst = 0;
        exp_err = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) exp_c[i][j] = 0;
        tick;
        fill_random(); send_all();
        run_burst("t6c", 0, 0, 2'b00, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
